// File: rtl/hist2d_event_binner.sv
// hist2d_event_binner: pops TDC-GPX words and groups them into START-delimited events.
// For each event with exactly four hits (one per channel) it bins X = CH1-CH2 and Y = CH3-CH4.
// The bin update is a +1 read-modify-write on the DDR2 controller port.
// It also provides a bin clear sweep and accepted/rejected event counters.
// Channel field fifo_dout[27:26]: 0 = CH1, 1 = CH2, 2 = CH3, 3 = CH4.
// Optional macro HIST2D_SAT_EN: when defined, a full bin stays at 2^DATA_W-1
// instead of wrapping to 0.
module hist2d_event_binner #(
    parameter int unsigned       TS_W      = 16,
    parameter int unsigned       BIN_BITS  = 10,
    parameter int unsigned       ADDR_W    = 30,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_start,
    output logic              clear_busy,
    input  logic [31:0]       fifo_dout,
    output logic              fifo_rd_en,
    input  logic              fifo_empty,
    input  logic              fifo_valid,
    input  logic              mem_ready,
    output logic              mem_op,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid,
    output logic [31:0]       evt_accepted,
    output logic [31:0]       evt_rejected
);

    localparam int unsigned IDX_W  = 2 * BIN_BITS;
    localparam int unsigned DIFF_W = TS_W + 1;
    localparam logic [31:0] MARKER = 32'hFFFF_FFFF;
    localparam logic signed [DIFF_W-1:0] WIN_HI = DIFF_W'((1 << (BIN_BITS - 1)) - 1);
    localparam logic signed [DIFF_W-1:0] WIN_LO = DIFF_W'(-(1 << (BIN_BITS - 1)));

    typedef enum logic [3:0] {
        IDLE, FETCH, EVAL, DIFF, RD_REQ, RD_WAIT, MODIFY,
        WR_REQ, WR_WAIT, CLEAR_EVT, CLR_WR, CLR_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0][TS_W-1:0]    ts_q, ts_d;
    logic [3:0]              hit_q, hit_d;
    logic [7:0]              hits_q, hits_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    clr_pend_q, clr_pend_d;
    logic                    clear_busy_q, clear_busy_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    wr_skip_q, wr_skip_d;
    logic                    fifo_rd_en_q, fifo_rd_en_d;
    logic                    mem_op_q, mem_op_d;
    logic                    mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]             acc_q, acc_d;
    logic [31:0]             rej_q, rej_d;

    logic signed [DIFF_W-1:0] dx_c, dy_c;
    logic [DIFF_W-1:0]        bx_c, by_c;
    logic                     in_win_c;
    logic [ADDR_W-1:0]        rmw_addr_c, clr_addr_c;
    logic [DATA_W-1:0]        inc_c;
    logic [1:0]               ch_c;
    logic                     sweeping_c;

    // Delay differences, window test and bin address of the current event
    assign dx_c       = $signed({1'b0, ts_q[0]}) - $signed({1'b0, ts_q[1]});
    assign dy_c       = $signed({1'b0, ts_q[2]}) - $signed({1'b0, ts_q[3]});
    assign bx_c       = DIFF_W'(dx_c - WIN_LO);
    assign by_c       = DIFF_W'(dy_c - WIN_LO);
    assign in_win_c   = (dx_c >= WIN_LO) && (dx_c <= WIN_HI) &&
                        (dy_c >= WIN_LO) && (dy_c <= WIN_HI);
    assign rmw_addr_c = BASE_ADDR + ADDR_W'({by_c[BIN_BITS-1:0], bx_c[BIN_BITS-1:0], 2'b00});
    assign clr_addr_c = BASE_ADDR + ADDR_W'({idx_q, 2'b00});
    assign ch_c       = fifo_dout[27:26];
    assign sweeping_c = (state_q == CLR_WR) || (state_q == CLR_WAIT);

    // Bin increment: wrap by default, hold at full scale when saturation is built in
`ifdef HIST2D_SAT_EN
    assign inc_c = (&rdata_q) ? rdata_q : rdata_q + DATA_W'(1);
`else
    assign inc_c = rdata_q + DATA_W'(1);
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        ts_d         = ts_q;
        hit_d        = hit_q;
        hits_d       = hits_q;
        rdata_d      = rdata_q;
        clr_pend_d   = clr_pend_q | (clear_start & ~sweeping_c);
        idx_d        = idx_q;
        wr_skip_d    = wr_skip_q;
        fifo_rd_en_d = 1'b0;
        mem_op_d     = 1'b0;
        mem_rw_d     = 1'b1;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        acc_d        = acc_q;
        rej_d        = rej_q;

        case (state_q)
            IDLE: begin
                if (clr_pend_q) begin
                    if ((hits_q != 8'd0) || (hit_q != 4'd0)) begin
                        state_d = CLEAR_EVT;
                    end else begin
                        clr_pend_d = 1'b0;
                        idx_d      = '0;
                        state_d    = CLR_WR;
                    end
                end else if (enable && !fifo_empty) begin
                    fifo_rd_en_d = 1'b1;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                if (fifo_valid) begin
                    if (fifo_dout == MARKER) begin
                        state_d = EVAL;
                    end else begin
                        ts_d[ch_c]  = fifo_dout[TS_W:1];
                        hit_d[ch_c] = 1'b1;
                        if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
                        state_d = IDLE;
                    end
                end
            end
            EVAL: begin
                if (hits_q == 8'd0) begin
                    state_d = IDLE;
                end else if ((hits_q == 8'd4) && (&hit_q)) begin
                    state_d = DIFF;
                end else begin
                    rej_d   = rej_q + 32'd1;
                    state_d = CLEAR_EVT;
                end
            end
            DIFF: begin
                if (in_win_c) begin
                    mem_addr_d = rmw_addr_c;
                    state_d    = RD_REQ;
                end else begin
                    rej_d   = rej_q + 32'd1;
                    state_d = CLEAR_EVT;
                end
            end
            RD_REQ: begin
                if (mem_ready) begin
                    mem_op_d = 1'b1;
                    mem_rw_d = 1'b1;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rdata_valid) begin
                    rdata_d = mem_rdata;
                    state_d = MODIFY;
                end
            end
            MODIFY: begin
                mem_wdata_d = inc_c;
                state_d     = WR_REQ;
            end
            WR_REQ: begin
                if (mem_ready) begin
                    mem_op_d  = 1'b1;
                    mem_rw_d  = 1'b0;
                    wr_skip_d = 1'b1;
                    state_d   = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (wr_skip_q) begin
                    wr_skip_d = 1'b0;
                end else if (mem_ready) begin
                    acc_d   = acc_q + 32'd1;
                    state_d = CLEAR_EVT;
                end
            end
            CLEAR_EVT: begin
                hit_d   = '0;
                ts_d    = '0;
                hits_d  = '0;
                state_d = IDLE;
            end
            CLR_WR: begin
                if (mem_ready) begin
                    mem_op_d    = 1'b1;
                    mem_rw_d    = 1'b0;
                    mem_addr_d  = clr_addr_c;
                    mem_wdata_d = '0;
                    wr_skip_d   = 1'b1;
                    state_d     = CLR_WAIT;
                end
            end
            CLR_WAIT: begin
                if (wr_skip_q) begin
                    wr_skip_d = 1'b0;
                end else if (mem_ready) begin
                    if (&idx_q) begin
                        acc_d   = '0;
                        rej_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = CLR_WR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        clear_busy_d = clr_pend_d || (state_d == CLR_WR) || (state_d == CLR_WAIT);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ts_q         <= '0;
            hit_q        <= '0;
            hits_q       <= '0;
            rdata_q      <= '0;
            clr_pend_q   <= 1'b0;
            clear_busy_q <= 1'b0;
            idx_q        <= '0;
            wr_skip_q    <= 1'b0;
            fifo_rd_en_q <= 1'b0;
            mem_op_q     <= 1'b0;
            mem_rw_q     <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            acc_q        <= '0;
            rej_q        <= '0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            hit_q        <= hit_d;
            hits_q       <= hits_d;
            rdata_q      <= rdata_d;
            clr_pend_q   <= clr_pend_d;
            clear_busy_q <= clear_busy_d;
            idx_q        <= idx_d;
            wr_skip_q    <= wr_skip_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            mem_op_q     <= mem_op_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            acc_q        <= acc_d;
            rej_q        <= rej_d;
        end
    end

    assign clear_busy   = clear_busy_q;
    assign fifo_rd_en   = fifo_rd_en_q;
    assign mem_op       = mem_op_q;
    assign mem_rw       = mem_rw_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign evt_accepted = acc_q;
    assign evt_rejected = rej_q;

endmodule

// File: tb/tb_hist2d_event_binner.sv
// Scoreboard bench for hist2d_event_binner.
// dut_a (BIN_BITS=10) exercises event binning. dut_b (BIN_BITS=4) exercises the clear sweep.
`timescale 1ns/1ps
module tb_hist2d_event_binner;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam logic [31:0] MARK = 32'hFFFF_FFFF;

    typedef struct { logic rw; logic [AW-1:0] addr; logic [DW-1:0] wdata; } op_t;
    typedef struct { string nm; int id; logic [31:0] exp; } chk_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // dut_a signals
    logic          enable_a, clear_start_a, clear_busy_a;
    logic [31:0]   fifo_dout_a = '0;
    logic          fifo_rd_en_a;
    logic          fifo_empty_a = 1'b1;
    logic          fifo_valid_a = 1'b0;
    logic          mem_ready_a, mem_op_a, mem_rw_a;
    logic [AW-1:0] mem_addr_a;
    logic [DW-1:0] mem_wdata_a;
    logic [DW-1:0] mem_rdata_a = '0;
    logic          mem_rdata_valid_a = 1'b0;
    logic [31:0]   evt_accepted_a, evt_rejected_a;

    // dut_b signals
    logic          enable_b, clear_start_b, clear_busy_b;
    logic [31:0]   fifo_dout_b = '0;
    logic          fifo_rd_en_b;
    logic          fifo_empty_b = 1'b1;
    logic          fifo_valid_b = 1'b0;
    logic          mem_ready_b, mem_op_b, mem_rw_b;
    logic [AW-1:0] mem_addr_b;
    logic [DW-1:0] mem_wdata_b, mem_rdata_b;
    logic          mem_rdata_valid_b;
    logic [31:0]   evt_accepted_b, evt_rejected_b;

    assign mem_ready_b       = 1'b1;
    assign mem_rdata_b       = '0;
    assign mem_rdata_valid_b = 1'b0;

    hist2d_event_binner #(.TS_W(16), .BIN_BITS(10), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(AW'(0))) dut_a (
        .clk(clk), .reset(reset), .enable(enable_a), .clear_start(clear_start_a),
        .clear_busy(clear_busy_a), .fifo_dout(fifo_dout_a), .fifo_rd_en(fifo_rd_en_a),
        .fifo_empty(fifo_empty_a), .fifo_valid(fifo_valid_a), .mem_ready(mem_ready_a),
        .mem_op(mem_op_a), .mem_rw(mem_rw_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(mem_rdata_a), .mem_rdata_valid(mem_rdata_valid_a),
        .evt_accepted(evt_accepted_a), .evt_rejected(evt_rejected_a));

    hist2d_event_binner #(.TS_W(16), .BIN_BITS(4), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(AW'(0))) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .clear_start(clear_start_b),
        .clear_busy(clear_busy_b), .fifo_dout(fifo_dout_b), .fifo_rd_en(fifo_rd_en_b),
        .fifo_empty(fifo_empty_b), .fifo_valid(fifo_valid_b), .mem_ready(mem_ready_b),
        .mem_op(mem_op_b), .mem_rw(mem_rw_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .mem_rdata_valid(mem_rdata_valid_b),
        .evt_accepted(evt_accepted_b), .evt_rejected(evt_rejected_b));

    logic [31:0] fifo_a_q[$];
    logic [31:0] fifo_b_q[$];
    op_t         exp_a[$];
    op_t         exp_b[$];
    chk_t        chk_q[$];
    logic [31:0] rd_value = '0;
    int          rd_cnt_a = 0;
    int          tests = 0;
    int          fails = 0;

    // TDC FIFO models: a pop presents the word with valid on the following cycle
    always @(posedge clk) begin
        if (fifo_rd_en_a && fifo_a_q.size() > 0) begin
            fifo_dout_a  <= fifo_a_q.pop_front();
            fifo_valid_a <= 1'b1;
        end else begin
            fifo_valid_a <= 1'b0;
        end
        if (fifo_rd_en_b && fifo_b_q.size() > 0) begin
            fifo_dout_b  <= fifo_b_q.pop_front();
            fifo_valid_b <= 1'b1;
        end else begin
            fifo_valid_b <= 1'b0;
        end
    end

    always @(negedge clk) begin
        fifo_empty_a <= (fifo_a_q.size() == 0);
        fifo_empty_b <= (fifo_b_q.size() == 0);
    end

    // Memory controller model for dut_a: read data returns three cycles after a read strobe
    always @(posedge clk) begin
        mem_rdata_valid_a <= 1'b0;
        if (rd_cnt_a == 1) begin
            mem_rdata_valid_a <= 1'b1;
            mem_rdata_a       <= rd_value;
        end
        if (rd_cnt_a > 0) rd_cnt_a <= rd_cnt_a - 1;
        if (mem_op_a && mem_rw_a) rd_cnt_a <= 3;
    end

    function automatic logic [31:0] probe(input int id);
        case (id)
            0:       return evt_accepted_a;
            1:       return evt_rejected_a;
            2:       return evt_accepted_b;
            3:       return evt_rejected_b;
            4:       return 32'(clear_busy_b);
            5:       return 32'(mem_rw_a);
            6:       return 32'(mem_op_a);
            7:       return 32'(fifo_rd_en_a);
            8:       return 32'(clear_busy_a);
            9:       return 32'(fifo_a_q.size());
            10:      return 32'(exp_a.size());
            11:      return 32'(exp_b.size());
            default: return '0;
        endcase
    endfunction

    // Monitor: checks every memory strobe against the scoreboard, then serves queued checks
    always @(negedge clk) begin
        op_t         e;
        chk_t        c;
        logic [31:0] act;
        if (mem_op_a) begin
            tests++;
            if (exp_a.size() == 0) begin
                fails++;
                $display("FAIL memop_a: got unexpected rw=%0b addr=%0d wdata=%h, required no op",
                         mem_rw_a, mem_addr_a, mem_wdata_a);
            end else begin
                e = exp_a.pop_front();
                if (mem_rw_a !== e.rw || mem_addr_a !== e.addr || (!e.rw && mem_wdata_a !== e.wdata)) begin
                    fails++;
                    $display("FAIL memop_a: got rw=%0b addr=%0d wdata=%h, required rw=%0b addr=%0d wdata=%h",
                             mem_rw_a, mem_addr_a, mem_wdata_a, e.rw, e.addr, e.wdata);
                end
            end
        end
        if (mem_op_b) begin
            tests++;
            if (exp_b.size() == 0) begin
                fails++;
                $display("FAIL memop_b: got unexpected rw=%0b addr=%0d wdata=%h, required no op",
                         mem_rw_b, mem_addr_b, mem_wdata_b);
            end else begin
                e = exp_b.pop_front();
                if (mem_rw_b !== e.rw || mem_addr_b !== e.addr || mem_wdata_b !== e.wdata ||
                    clear_busy_b !== 1'b1) begin
                    fails++;
                    $display("FAIL memop_b: got rw=%0b addr=%0d wdata=%h busy=%0b, required rw=%0b addr=%0d wdata=%h busy=1",
                             mem_rw_b, mem_addr_b, mem_wdata_b, clear_busy_b, e.rw, e.addr, e.wdata);
                end
            end
        end
        if (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            tests++;
            if (c.id == 99) begin
                fails++;
                $display("FAIL %s: wait bound expired, required completion", c.nm);
            end else begin
                act = probe(c.id);
                if (act !== c.exp) begin
                    fails++;
                    $display("FAIL %s: got %0d, required %0d", c.nm, act, c.exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input int id, input logic [31:0] exp);
        chk_t c;
        c.nm  = nm;
        c.id  = id;
        c.exp = exp;
        chk_q.push_back(c);
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] hw(input int ch, input int ts);
        logic [31:0] w  = '0;
        logic [1:0]  c2 = 2'(ch);
        logic [15:0] t  = 16'(ts);
        w[27:26] = c2;
        w[16:1]  = t;
        return w;
    endfunction

    function automatic op_t mk_op(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        op_t o;
        o.rw    = rw;
        o.addr  = addr;
        o.wdata = wd;
        return o;
    endfunction

    task automatic ev_a(input int t1, input int t2, input int t3, input int t4);
        fifo_a_q.push_back(hw(0, t1));
        fifo_a_q.push_back(hw(1, t2));
        fifo_a_q.push_back(hw(2, t3));
        fifo_a_q.push_back(hw(3, t4));
        fifo_a_q.push_back(MARK);
    endtask

    task automatic exp_rmw_a(input logic [AW-1:0] addr, input logic [DW-1:0] rd, input logic [DW-1:0] wd);
        rd_value = rd;
        exp_a.push_back(mk_op(1'b1, addr, '0));
        exp_a.push_back(mk_op(1'b0, addr, wd));
    endtask

    task automatic settle_a();
        int n = 0;
        while ((fifo_a_q.size() != 0 || exp_a.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("settle_a", 99, '0);
        repeat (20) @(negedge clk);
    endtask

    task automatic settle_b();
        int n = 0;
        while (fifo_b_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("settle_b", 99, '0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] full_wd;
        int            n;
        reset = 1'b1;
        enable_a = 1'b0; clear_start_a = 1'b0; mem_ready_a = 1'b1;
        enable_b = 1'b0; clear_start_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_rw", 5, 1);
        chk("rst_mem_op", 6, 0);
        chk("rst_fifo_rd_en", 7, 0);
        chk("rst_clear_busy", 8, 0);
        chk("rst_accepted", 0, 0);
        chk("rst_rejected", 1, 0);
        reset = 1'b0;
        enable_a = 1'b1;
        enable_b = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal event: dx=10 -> bx=522, dy=-10 -> by=502
        exp_rmw_a(AW'(2058280), 32'd5, 32'd6);
        ev_a(1000, 990, 500, 510);
        settle_a();
        chk("e1_accepted", 0, 1);
        chk("e1_rejected", 1, 0);

        // Three hits only
        fifo_a_q.push_back(hw(0, 1));
        fifo_a_q.push_back(hw(1, 2));
        fifo_a_q.push_back(hw(2, 3));
        fifo_a_q.push_back(MARK);
        settle_a();
        chk("three_hits_rejected", 1, 1);
        chk("three_hits_accepted", 0, 1);

        // dx=+512 is just outside the window
        ev_a(1512, 1000, 700, 700);
        settle_a();
        chk("dx_p512_rejected", 1, 2);

        // dx=-512 -> bx=0, dy=0 -> by=512
        exp_rmw_a(AW'(2097152), 32'd0, 32'd1);
        ev_a(1000, 1512, 700, 700);
        settle_a();
        chk("dx_m512_accepted", 0, 2);

        // dx=+511 -> bx=1023, dy=-512 -> by=0
        exp_rmw_a(AW'(4092), 32'd7, 32'd8);
        ev_a(1511, 1000, 100, 612);
        settle_a();
        chk("edge_bins_accepted", 0, 3);

        // Duplicate CH1 gives five hits
        fifo_a_q.push_back(hw(0, 5));
        fifo_a_q.push_back(hw(0, 6));
        fifo_a_q.push_back(hw(1, 7));
        fifo_a_q.push_back(hw(2, 8));
        fifo_a_q.push_back(hw(3, 9));
        fifo_a_q.push_back(MARK);
        settle_a();
        chk("dup_rejected", 1, 3);

        // Next valid event after the duplicate: dx=0 -> bx=512, dy=1 -> by=513
        exp_rmw_a(AW'(2103296), 32'd41, 32'd42);
        ev_a(2000, 2000, 3000, 2999);
        settle_a();
        chk("after_dup_accepted", 0, 4);

        // Full bin, held back by enable low first
`ifdef HIST2D_SAT_EN
        full_wd = 32'hFFFF_FFFF;
`else
        full_wd = 32'h0000_0000;
`endif
        enable_a = 1'b0;
        exp_rmw_a(AW'(2099200), 32'hFFFF_FFFF, full_wd);
        ev_a(10, 10, 10, 10);
        repeat (30) @(negedge clk);
        chk("enable_low_no_pop", 9, 5);
        enable_a = 1'b1;
        settle_a();
        chk("full_bin_accepted", 0, 5);

        // Empty event: marker with no hits changes nothing
        fifo_a_q.push_back(MARK);
        settle_a();
        chk("empty_evt_accepted", 0, 5);
        chk("empty_evt_rejected", 1, 3);

        // dut_b: rejected event, then partial event interrupted by a clear
        fifo_b_q.push_back(hw(0, 1));
        fifo_b_q.push_back(hw(1, 2));
        fifo_b_q.push_back(hw(2, 3));
        fifo_b_q.push_back(MARK);
        settle_b();
        chk("b_rejected_pre", 3, 1);
        fifo_b_q.push_back(hw(0, 100));
        fifo_b_q.push_back(hw(1, 100));
        settle_b();
        for (int i = 0; i < 256; i++) exp_b.push_back(mk_op(1'b0, AW'(i * 4), '0));
        clear_start_b = 1'b1;
        @(negedge clk);
        clear_start_b = 1'b0;
        chk("clear_busy_rise", 4, 1);
        repeat (200) @(negedge clk);
        clear_start_b = 1'b1;
        @(negedge clk);
        clear_start_b = 1'b0;
        n = 0;
        while (clear_busy_b && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("clear_sweep_done", 99, '0);
        repeat (20) @(negedge clk);
        chk("clear_writes_left", 11, 0);
        chk("clear_busy_fall", 4, 0);
        chk("clear_accepted_zero", 2, 0);
        chk("clear_rejected_zero", 3, 0);
        fifo_b_q.push_back(hw(2, 5));
        fifo_b_q.push_back(hw(3, 5));
        fifo_b_q.push_back(MARK);
        settle_b();
        chk("partial_discarded", 3, 1);
        chk("partial_accepted", 2, 0);

        // Reset while a read-modify-write is in flight
        rd_value = 32'd1;
        exp_a.push_back(mk_op(1'b1, AW'(2103296), '0));
        ev_a(2000, 2000, 3000, 2999);
        n = 0;
        while (exp_a.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("rmw_read_seen", 99, '0);
        reset = 1'b1;
        chk("rst_mid_rmw_op", 6, 0);
        chk("rst_mid_rmw_accepted", 0, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid_rmw_no_write", 10, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
